// File: rtl/muldiv_if.sv
// muldiv_if: start/done handshake bundle for muldiv_unit.
//   master: drives start, op, dataa, datab, flush; observes busy, done, result.
//   slave : the unit itself.
//   start  - request, taken only when the unit is idle or finishing
//   op     - RV32M funct3 operation select
//   dataa  - rs1 (multiplicand / dividend)
//   datab  - rs2 (multiplier / divisor)
//   flush  - abort the operation in flight
//   busy   - iteration in progress
//   done   - one-cycle completion pulse
//   result - final result, held until the next accepted start
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dataa, datab, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dataa, datab, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle.
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - muldiv_if slave (start/op/dataa/datab/flush in, busy/done/result out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; busy=0, done=0
// S_CALC | WIDTH shift-add / shift-subtract iterations; busy=1
// S_DONE | result valid, done=1 for exactly one cycle; start accepted
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic               neg_q;    // product / quotient sign
  logic               neg_r;    // remainder sign
  logic [WIDTH-1:0]   b_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]      cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Operand preparation at accept.
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  assign sa = bus.dataa[WIDTH-1] &
              (bus.op == 3'b001 || bus.op == 3'b010 || bus.op == 3'b100 || bus.op == 3'b110);
  assign sb = bus.datab[WIDTH-1] &
              (bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110);
  assign mag_a = sa ? -bus.dataa : bus.dataa;
  assign mag_b = sb ? -bus.datab : bus.datab;

  assign div_zero = bus.op[2] && (bus.datab == '0);
  assign div_ovf  = bus.op[2] && !bus.op[0] && (bus.dataa == MIN_NEG) && (bus.datab == '1);
  assign special  = div_zero || div_ovf;
  // op[1] separates remainder ops from quotient ops.
  assign special_res = div_zero ? (bus.op[1] ? bus.dataa : '1)
                                : (bus.op[1] ? '0 : bus.dataa);

  // One multiply step: conditional add into the high half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step: shift left, trial-subtract the divisor.
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_nxt;
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign q_bit    = (rem_sh >= {1'b0, b_q});
  assign rem_new  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_nxt  = {rem_new, acc[WIDTH-2:0], q_bit};

  logic [2*WIDTH-1:0] acc_nxt;
  assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

  // Sign-corrected final values, taken from the last iteration's output.
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f, rem_f, fin;
  assign prod_f = neg_q ? -mul_nxt : mul_nxt;
  assign quo_f  = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  assign rem_f  = neg_r ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    fin = '0;
    case (op_q)
      3'b000:                 fin = prod_f[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_f[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin = quo_f;
      default:                fin = rem_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
          if (!bus.flush && bus.start) begin
            op_q  <= bus.op;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            b_q   <= bus.op[2] ? mag_b : mag_a;
            acc   <= {{WIDTH{1'b0}}, (bus.op[2] ? mag_a : mag_b)};
            cnt   <= '0;
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              result_q <= fin;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   dc, bc, cyc, dcount;

  muldiv_if #(.WIDTH(32)) m32 ();
  muldiv_if #(.WIDTH(8))  m8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(m32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(m8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or budget end).
  // Cycle 0 is the accept cycle. pulse_at>0 injects a stray start during that cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output int done_cyc, output int busy_cnt);
    int c;
    m32.start = 1'b1;
    m32.op    = o;
    m32.dataa = a;
    m32.datab = b;
    @(posedge clk);
    #1;
    m32.start = 1'b0;
    m32.op    = ~o;
    m32.dataa = ~a;
    m32.datab = ~b;
    done_cyc = -1;
    busy_cnt = 0;
    c = 0;
    while (done_cyc < 0 && c < 45) begin
      @(negedge clk);
      c++;
      if (c == pulse_at) begin
        m32.start = 1'b1;
        m32.op    = 3'b000;
        m32.dataa = 32'd1;
        m32.datab = 32'd1;
      end else begin
        m32.start = 1'b0;
      end
      if (m32.busy) busy_cnt++;
      if (m32.done) done_cyc = c;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    m32.start = 1'b0; m32.op = 3'b000; m32.dataa = '0; m32.datab = '0; m32.flush = 1'b0;
    m8.start  = 1'b0; m8.op  = 3'b000; m8.dataa  = '0; m8.datab  = '0; m8.flush  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", m32.busy, 0);
    chk("reset done", m32.done, 0);
    chk("reset result", m32.result, 0);
    chk("reset8 result", m8.result, 0);
    rst_n = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFFFFFA, 0, dc, bc);
    chk("mul done cyc", dc, 33);
    chk("mul busy cnt", bc, 32);
    chk("mul result", m32.result, 32'hFFFFFFD6);
    @(negedge clk);
    chk("idle after done", m32.done, 0);

    run_op(3'b001, 32'h80000000, 32'h80000000, 0, dc, bc);
    chk("mulh result", m32.result, 32'h40000000);
    @(negedge clk);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, dc, bc);
    chk("mulhu result", m32.result, 32'hFFFFFFFE);
    @(negedge clk);
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, 0, dc, bc);
    chk("mulhsu result", m32.result, 32'hFFFFFFFF);
    @(negedge clk);
    run_op(3'b000, 32'd0, 32'd5, 0, dc, bc);
    chk("mul zero done cyc", dc, 33);
    chk("mul zero result", m32.result, 0);

    @(negedge clk);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 0, dc, bc);
    chk("div done cyc", dc, 33);
    chk("div result", m32.result, 32'hFFFFFFFD);
    @(negedge clk);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 0, dc, bc);
    chk("rem done cyc", dc, 33);
    chk("rem result", m32.result, 32'hFFFFFFFF);
    @(negedge clk);
    run_op(3'b101, 32'd100, 32'd7, 0, dc, bc);
    chk("divu done cyc", dc, 33);
    chk("divu result", m32.result, 32'd14);
    // back-to-back: start issued in the DONE cycle
    run_op(3'b111, 32'd100, 32'd7, 0, dc, bc);
    chk("b2b done cyc", dc, 33);
    chk("b2b busy cnt", bc, 32);
    chk("remu result", m32.result, 32'd2);

    @(negedge clk);
    run_op(3'b101, 32'd5, 32'd0, 0, dc, bc);
    chk("divu0 done cyc", dc, 1);
    chk("divu0 busy cnt", bc, 0);
    chk("divu0 result", m32.result, 32'hFFFFFFFF);
    @(negedge clk);
    run_op(3'b110, 32'd5, 32'd0, 0, dc, bc);
    chk("rem0 done cyc", dc, 1);
    chk("rem0 result", m32.result, 32'd5);
    @(negedge clk);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 0, dc, bc);
    chk("divovf done cyc", dc, 1);
    chk("divovf busy cnt", bc, 0);
    chk("divovf result", m32.result, 32'h80000000);
    @(negedge clk);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 0, dc, bc);
    chk("removf result", m32.result, 32'd0);

    // stray start during CALC must be ignored
    @(negedge clk);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, dc, bc);
    chk("ignore start done cyc", dc, 33);
    chk("ignore start result", m32.result, 32'hFFFFFFFE);

    // flush at cycle 10
    @(negedge clk);
    m32.start = 1'b1; m32.op = 3'b101; m32.dataa = 32'd100; m32.datab = 32'd7;
    @(negedge clk);
    m32.start = 1'b0;
    for (int i = 2; i <= 10; i++) @(negedge clk);
    chk("flush busy before", m32.busy, 1);
    m32.flush = 1'b1;
    @(negedge clk);
    m32.flush = 1'b0;
    chk("flush busy after", m32.busy, 0);
    chk("flush result hold", m32.result, 32'hFFFFFFFE);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m32.done) dcount++;
    end
    chk("flush no done", dcount, 0);
    chk("flush result later", m32.result, 32'hFFFFFFFE);

    // reset at cycle 20 of a new operation
    m32.start = 1'b1; m32.op = 3'b000; m32.dataa = 32'd7; m32.datab = 32'hFFFFFFFA;
    @(negedge clk);
    m32.start = 1'b0;
    for (int i = 2; i <= 20; i++) @(negedge clk);
    chk("rst busy before", m32.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst busy", m32.busy, 0);
    chk("rst done", m32.done, 0);
    chk("rst result", m32.result, 0);

    // WIDTH=8: DIV -7/2
    @(negedge clk);
    m8.start = 1'b1; m8.op = 3'b100; m8.dataa = 8'hF9; m8.datab = 8'h02;
    @(posedge clk);
    #1;
    m8.start = 1'b0; m8.dataa = 8'h00; m8.datab = 8'h00;
    cyc = 0; dc = -1; bc = 0;
    while (dc < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (m8.busy) bc++;
      if (m8.done) dc = cyc;
    end
    chk("w8 done cyc", dc, 9);
    chk("w8 busy cnt", bc, 8);
    chk("w8 result", m8.result, 8'hFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; next-generation companion to the single-cycle integer ALU.
- Implements the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable WIDTH.
- Uses a start/done handshake. Sits beside the ALU in the execute stage; the core stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer of at least 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  3  operation select, RV funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- dataa  input  WIDTH  rs1 operand (multiplicand / dividend).
- datab  input  WIDTH  rs2 operand (multiplier / divisor).
- flush  input  1  abort the current operation.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  final result; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0. Reset overrides start and flush, including mid-operation.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Acceptance: start=1 in IDLE or DONE (back-to-back allowed) latches op, dataa and datab; later input changes are ignored. start in CALC is ignored.
- Operand prep at accept: signedness per op.
  - Signed operands: MULH both, MULHSU dataa only, DIV/REM both.
  - MUL result is sign-agnostic and computed unsigned.
  - Magnitudes (absolute values) are latched, plus result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Multiply: radix-2 shift-add over a 2*WIDTH accumulator, one bit per cycle, WIDTH CALC cycles.
  - Final value is the magnitude product, negated (2's complement, 2*WIDTH bits) if the sign is set.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide: restoring shift-subtract, one quotient bit per cycle, WIDTH CALC cycles.
  - Quotient and remainder are sign-corrected as above.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Latency: start in cycle 0 → CALC cycles 1..WIDTH → result register written at the end of cycle WIDTH → done=1 in cycle WIDTH+1 (33 for WIDTH=32).
  - DONE → IDLE next cycle unless start is accepted.
- Counter: counts WIDTH iterations; width $clog2(WIDTH)+1; leaves CALC when it reaches WIDTH.
- Special cases, detected at accept; skip CALC; state → DONE, done=1 in cycle 1:
  - Divide by zero (datab=0): DIV/DIVU quotient = all ones; REM/REMU = dataa.
  - Signed overflow (DIV/REM, dataa = 1<<(WIDTH-1), datab = all ones): DIV = dataa; REM = 0.
  - Divide by zero takes precedence over overflow.
- Multiply has no special cases; a zero operand still takes the full latency.
- flush:
  - flush=1 in CALC → IDLE next cycle; no done; result unchanged.
  - flush in DONE → IDLE; the done pulse of that cycle still stands.
  - flush has priority over start in the same cycle.
- result changes only at the completion edge (normal or special); stable at all other times.

Test Plan:
- WIDTH=32, MUL dataa=7, datab=0xFFFFFFFA (-6), start cycle 0 → busy cycles 1-32, done cycle 33, result=0xFFFFFFD6 (-42).
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF (-1) × 2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2; each with done at cycle 33.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. All with done in cycle 1, busy never high.
- Back-to-back: second start in the DONE cycle is accepted, done again 33 cycles later. start during CALC is ignored and the original result is returned.
- Abort/reset: flush at cycle 10 → IDLE at 11, no done, result holds its previous value. rst_n=0 at cycle 20 of a new op → all outputs 0 next cycle. WIDTH=8 rerun: DIV 0x F9/0x02 (-7/2) → 0xFD, done at cycle 9.
